alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter XLEN, default 32: operand/result width; legal values 8, 16, 32, 64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  operation presented.
REQ-005 in_ready  output  1  unit can accept an operation this cycle.
REQ-006 alu_op  input  2  class: 00 load/store add, 01 branch compare, 10 R-type, 11 reserved.
REQ-007 funct7  input  7  R-type function modifier.
REQ-008 funct3  input  3  function select.
REQ-009 op_a  input  XLEN  first operand.
REQ-010 op_b  input  XLEN  second operand; shifts use low log2(XLEN) bits as shamt.
REQ-011 out_valid  output  1  result held and valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 result  output  XLEN  operation result.
REQ-014 taken  output  1  branch condition true (alu_op=01 only, else 0).
REQ-015 illegal  output  1  decode matched no supported encoding.

Function
REQ-016 Accept occurs on an edge where in_valid && in_ready; inputs are sampled only then.
REQ-017 in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-018 States: IDLE, BUSY; BUSY is entered only for multiply; all other ops stay in IDLE.
REQ-019 Single-cycle ops: result/taken/illegal registered on the accept edge; out_valid=1 the following cycle (latency 1).
REQ-020 alu_op=00: result = op_a + op_b, modulo 2^XLEN; funct7/funct3 ignored.
REQ-021 alu_op=01: result = op_a - op_b; taken per funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 are illegal.
REQ-022 alu_op=10, funct7=0000000: funct3 000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl, 110 or, 111 and.
REQ-023 alu_op=10, funct7=0100000: funct3 000 sub, 101 sra (sign-filling); other funct3 values are illegal.
REQ-024 slt/sltu: result = {XLEN-1 zeros, compare bit}.
REQ-025 Illegal encoding, including alu_op=11: result=0, taken=0, illegal=1, latency 1; no other side effect.
REQ-026 out_valid held, and result/taken/illegal held stable, until an edge with out_ready=1; out_valid clears on that edge unless a new accept occurs on the same edge, in which case it stays 1 with the new result (back-to-back throughput 1/cycle).
REQ-027 out_ready with out_valid=0 has no effect.

Reset
REQ-028 rst_n low asynchronously forces state=IDLE, out_valid=0, result=0, taken=0, illegal=0, multiply counter=0.
REQ-029 Reset mid-multiply abandons the operation; no result is produced after release.
REQ-030 in_ready=1 in the first cycle after rst_n deasserts.

Configuration
REQ-031 Macro ALU_EXEC_MUL_EN defined: alu_op=10, funct7=0000001, funct3=000 (mul) is legal; unit enters BUSY on accept, runs an iterative shift-add over XLEN cycles, and asserts out_valid with the low XLEN bits of op_a*op_b exactly XLEN cycles after the accept edge, then returns to IDLE.
REQ-032 In BUSY, in_ready=0; out_valid stays 0 until the product is presented.
REQ-033 Macro undefined: funct7=0000001 is illegal per REQ-025; no BUSY state or multiplier logic is synthesised.

Verification
REQ-034 XLEN=32, alu_op=00, a=0xFFFFFFFF, b=1 -> next cycle out_valid=1, result=0, illegal=0.
REQ-035 alu_op=01, funct3=100, a=0xFFFFFFFE (-2), b=1 -> taken=1; same operands with funct3=110 -> taken=0.
REQ-036 alu_op=10, funct7=0100000, funct3=101, a=0x80000000, b=4 -> result=0xF8000000; funct7=0 -> result=0x08000000.
REQ-037 out_ready=0 for 3 cycles after a result -> out_valid and result held, in_ready=0; out_ready=1 with in_valid=1 -> new result on the next cycle, no gap.
REQ-038 ALU_EXEC_MUL_EN defined: mul a=7, b=0xFFFFFFFF -> in_ready=0 for 32 cycles, then result=0xFFFFFFF9; a second mul with rst_n pulsed low at cycle 10 -> out_valid never asserts, in_ready=1 after release.
REQ-039 Macro undefined: funct7=0000001, funct3=000 -> latency 1, illegal=1, result=0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Integer execute unit: add, branch compare and R-type ALU ops with a registered valid/ready result.
// Optional macro ALU_EXEC_MUL_EN adds an iterative shift-add multiplier (mul) that occupies the unit for XLEN cycles.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            taken,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  logic            r_out_valid;
  logic [XLEN-1:0] r_result;
  logic            r_taken;
  logic            r_illegal;

  logic            w_accept;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_diff;
  logic            w_lt;
  logic            w_ltu;
  logic [XLEN-1:0] w_res;
  logic            w_taken;
  logic            w_illegal;
  logic            w_is_mul;
  logic            w_mul_done;
  logic [XLEN-1:0] w_mul_product;

  assign w_accept = in_valid && in_ready;
  assign w_shamt  = op_b[SHW-1:0];
  assign w_sum    = op_a + op_b;
  assign w_diff   = op_a - op_b;
  assign w_lt     = $signed(op_a) < $signed(op_b);
  assign w_ltu    = op_a < op_b;

  // NOTE: every output of an always_comb gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_res     = '0;
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    w_is_mul  = 1'b0;
    case (alu_op)
      2'b00: w_res = w_sum;
      2'b01: begin
        w_res = w_diff;
        case (funct3)
          3'b000:  w_taken = (op_a == op_b);
          3'b001:  w_taken = (op_a != op_b);
          3'b100:  w_taken = w_lt;
          3'b101:  w_taken = !w_lt;
          3'b110:  w_taken = w_ltu;
          3'b111:  w_taken = !w_ltu;
          default: w_illegal = 1'b1;
        endcase
      end
      2'b10: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  w_res = w_sum;
            3'b001:  w_res = op_a << w_shamt;
            3'b010:  w_res = {{(XLEN-1){1'b0}}, w_lt};
            3'b011:  w_res = {{(XLEN-1){1'b0}}, w_ltu};
            3'b100:  w_res = op_a ^ op_b;
            3'b101:  w_res = op_a >> w_shamt;
            3'b110:  w_res = op_a | op_b;
            default: w_res = op_a & op_b;
          endcase
        end else if (funct7 == 7'b0100000) begin
          case (funct3)
            3'b000:  w_res = w_diff;
            3'b101:  w_res = $signed(op_a) >>> w_shamt;
            default: w_illegal = 1'b1;
          endcase
`ifdef ALU_EXEC_MUL_EN
        end else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
          w_is_mul = 1'b1;
`endif
        end else begin
          w_illegal = 1'b1;
        end
      end
      default: w_illegal = 1'b1;
    endcase
    // Illegal encodings must report a clean zero result even where a partial decode produced one.
    if (w_illegal) begin
      w_res   = '0;
      w_taken = 1'b0;
    end
  end

`ifdef ALU_EXEC_MUL_EN
  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [SHW-1:0]   r_cnt;
  logic [XLEN-1:0]  r_mcand;
  logic [XLEN-1:0]  r_mplier;
  logic [XLEN-1:0]  r_acc;

  // The last BUSY edge folds in the final multiplier bit, so the product lands exactly XLEN edges after accept.
  assign w_mul_done    = (r_state == ST_BUSY) && (r_cnt == SHW'(XLEN-1));
  assign w_mul_product = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign in_ready      = (r_state == ST_IDLE) && (!r_out_valid || out_ready);

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_is_mul) w_state_next = ST_BUSY;
      ST_BUSY: if (w_mul_done)           w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (w_accept && w_is_mul) begin
      r_cnt    <= '0;
      r_mcand  <= op_a;
      r_mplier <= op_b;
      r_acc    <= '0;
    end else if (r_state == ST_BUSY) begin
      r_cnt    <= r_cnt + SHW'(1);
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_acc    <= w_mul_product;
    end
  end
`else
  assign w_mul_done    = 1'b0;
  assign w_mul_product = '0;
  assign in_ready      = !r_out_valid || out_ready;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_taken     <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_taken     <= w_taken;
      r_illegal   <= w_illegal;
    end else if (w_accept) begin
      r_out_valid <= 1'b0;
    end else if (w_mul_done) begin
      r_out_valid <= 1'b1;
      r_result    <= w_mul_product;
      r_taken     <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign taken     = r_taken;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit (XLEN=32): directed vectors push expectations, a monitor checks outputs.
module tb_alu_exec_unit;

  typedef struct {
    logic [31:0] res;
    logic        tkn;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  alu_op = '0;
  logic [6:0]  funct7 = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        taken;
  logic        illegal;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct7    (funct7),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .taken     (taken),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waits (bounded) for in_ready, presents one operation for one accept edge, returns at accept edge + 1.
  task automatic issue(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic et, input logic ei);
    exp_t e;
    int   w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    check("in_ready_before_issue", in_ready, 1);
    alu_op = op; funct7 = f7; funct3 = f3; op_a = a; op_b = b;
    in_valid = 1'b1;
    e.res = er; e.tkn = et; e.ill = ei;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every cycle a result is presented it must match the oldest expectation; it retires on out_ready.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          check("result",  result,  sb[0].res);
          check("taken",   taken,   sb[0].tkn);
          check("illegal", illegal, sb[0].ill);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_result",    result,    0);
    check("rst_taken",     taken,     0);
    check("rst_illegal",   illegal,   0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", in_ready, 1);

    // Add wraps modulo 2^32, latency 1.
    issue(2'b00, 7'h7F, 3'b111, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 1'b0);
    check("add_latency_out_valid", out_valid, 1);

    // Branch compares: result is a-b, taken per funct3.
    issue(2'b01, 7'h00, 3'b100, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b1, 1'b0);
    issue(2'b01, 7'h00, 3'b110, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 1'b0);
    issue(2'b01, 7'h00, 3'b000, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0);
    issue(2'b01, 7'h00, 3'b001, 32'd5, 32'd5, 32'h0, 1'b0, 1'b0);
    issue(2'b01, 7'h00, 3'b101, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 1'b0);
    issue(2'b01, 7'h00, 3'b111, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b1, 1'b0);
    issue(2'b01, 7'h00, 3'b010, 32'd9, 32'd3, 32'h0, 1'b0, 1'b1);

    // Shifts, compares and logic.
    issue(2'b10, 7'h20, 3'b101, 32'h80000000, 32'd4,  32'hF8000000, 1'b0, 1'b0);
    issue(2'b10, 7'h00, 3'b101, 32'h80000000, 32'd4,  32'h08000000, 1'b0, 1'b0);
    issue(2'b10, 7'h00, 3'b101, 32'h80000000, 32'h24, 32'h08000000, 1'b0, 1'b0);
    issue(2'b10, 7'h00, 3'b001, 32'd1, 32'd31, 32'h80000000, 1'b0, 1'b0);
    issue(2'b10, 7'h00, 3'b010, 32'hFFFFFFFF, 32'd1, 32'h1, 1'b0, 1'b0);
    issue(2'b10, 7'h00, 3'b011, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 1'b0);
    issue(2'b10, 7'h00, 3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0);
    issue(2'b10, 7'h00, 3'b110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0);
    issue(2'b10, 7'h00, 3'b111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0);
    issue(2'b10, 7'h20, 3'b000, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b0);
    issue(2'b10, 7'h00, 3'b000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b0);
    issue(2'b10, 7'h20, 3'b001, 32'd1, 32'd1, 32'h0, 1'b0, 1'b1);
    issue(2'b11, 7'h00, 3'b000, 32'd1, 32'd2, 32'h0, 1'b0, 1'b1);

    // Backpressure: result held for 3 stalled cycles, then release with back-to-back accept.
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(2'b00, 7'h00, 3'b000, 32'd10, 32'd20, 32'h1E, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready",  in_ready,  0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(2'b00, 7'h00, 3'b000, 32'h100, 32'd1, 32'h101, 1'b0, 1'b0);
    check("no_gap_out_valid", out_valid, 1);
    @(posedge clk); #1;

`ifdef ALU_EXEC_MUL_EN
    issue(2'b10, 7'h01, 3'b000, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0, 1'b0);
    cnt = 0;
    while (!in_ready && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    check("mul_busy_cycles", cnt, 32);
    check("mul_out_valid", out_valid, 1);
    @(posedge clk); #1;
    issue(2'b10, 7'h01, 3'b000, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    sb.delete();
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_mul_reset", in_ready, 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) cnt++;
      @(posedge clk); #1;
    end
    check("abandoned_mul_out_valid_cycles", cnt, 0);
`else
    issue(2'b10, 7'h01, 3'b000, 32'd7, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1);
    check("mul_disabled_latency", out_valid, 1);
    @(posedge clk); #1;
`endif

    // Asynchronous reset clears a pending result without waiting for a clock edge.
    out_ready = 1'b0;
    issue(2'b00, 7'h00, 3'b000, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_result",    result,    0);
    out_ready = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_async_reset", in_ready, 1);

    repeat (3) begin
      @(posedge clk); #1;
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
